// File: rtl/i2c_target_responder.sv
// I2C target responder: synchronises SCL/SDA, decodes START/STOP, matches a
// 7-bit device address and serves a byte-wide register file that is also
// reachable from a direct host port.
module i2c_target_responder #(
  parameter logic [6:0]  DEVICE_ADDR = 7'h50,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        axi_clk,
  input  logic                        axi_reset,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_drive_low,
  input  logic [$clog2(NUM_REGS)-1:0] host_addr,
  input  logic [7:0]                  host_wdata,
  input  logic                        host_we,
  output logic [7:0]                  host_rdata,
  output logic                        busy,
  output logic                        wr_byte_pulse,
  output logic                        nack_seen
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   rw;
  logic                   rd_acked;
  logic [AW-1:0]          ptr;
  logic [7:0]             regfile [NUM_REGS];
  logic [7:0]             rx_byte;
  logic                   i2c_we;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {shreg[6:0], sda_s};

  // Last data bit of a write byte lands in the file in the same cycle it is sampled
  assign i2c_we = (state == WR_DATA) && scl_rise && (bit_cnt == 4'd7)
                  && !start_det && !stop_det;

  assign host_rdata = regfile[host_addr];

  // Pad synchronisers plus one delay flop each; idle bus level is high
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // Register file: host write first, a coincident I2C write to the same index wins
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regfile[i] <= 8'h00;
      end
    end else begin
      if (host_we) begin
        regfile[host_addr] <= host_wdata;
      end
      if (i2c_we) begin
        regfile[ptr] <= rx_byte;
      end
    end
  end

  // Protocol FSM: samples on SCL rise, moves SDA only on SCL fall
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state         <= IDLE;
      bit_cnt       <= 4'd0;
      shreg         <= 8'h00;
      rw            <= 1'b0;
      rd_acked      <= 1'b0;
      ptr           <= '0;
      busy          <= 1'b0;
      sda_drive_low <= 1'b0;
      wr_byte_pulse <= 1'b0;
      nack_seen     <= 1'b0;
    end else begin
      wr_byte_pulse <= 1'b0;
      nack_seen     <= 1'b0;
      if (start_det) begin
        state         <= ADDR;
        bit_cnt       <= 4'd0;
        busy          <= 1'b0;
        sda_drive_low <= 1'b0;
      end else if (stop_det) begin
        state         <= IDLE;
        bit_cnt       <= 4'd0;
        busy          <= 1'b0;
        sda_drive_low <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          ADDR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shreg[7:1] == DEVICE_ADDR) begin
                sda_drive_low <= 1'b1;
                busy          <= 1'b1;
                rw            <= shreg[0];
                state         <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                shreg         <= regfile[ptr];
                sda_drive_low <= ~regfile[ptr][7];
                bit_cnt       <= 4'd1;
                state         <= RD_DATA;
              end else begin
                sda_drive_low <= 1'b0;
                bit_cnt       <= 4'd0;
                state         <= PTR;
              end
            end
          end
          PTR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                ptr <= rx_byte[AW-1:0];
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_drive_low <= 1'b1;
              bit_cnt       <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              sda_drive_low <= 1'b0;
              bit_cnt       <= 4'd0;
              state         <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                wr_byte_pulse <= 1'b1;
                ptr           <= ptr + AW'(1);
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_drive_low <= 1'b1;
              bit_cnt       <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              sda_drive_low <= 1'b0;
              bit_cnt       <= 4'd0;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt < 4'd8) begin
                sda_drive_low <= ~shreg[3'(4'd7 - bit_cnt)];
                bit_cnt       <= bit_cnt + 4'd1;
              end else begin
                sda_drive_low <= 1'b0;
                rd_acked      <= 1'b0;
                state         <= RD_ACK;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ptr      <= ptr + AW'(1);
                rd_acked <= 1'b1;
              end else begin
                nack_seen <= 1'b1;
                busy      <= 1'b0;
                state     <= IGNORE;
              end
            end else if (scl_fall && rd_acked) begin
              shreg         <= regfile[ptr];
              sda_drive_low <= ~regfile[ptr][7];
              bit_cnt       <= 4'd1;
              state         <= RD_DATA;
            end
          end
          IGNORE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-banged I2C controller, open-drain SDA
// model, table of write transfers plus hand-written read/reset corner cases.
module tb_i2c_target_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_ctl;
  logic       sda_line;
  logic       sda_drive_low;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_we;
  logic [7:0] host_rdata;
  logic       busy;
  logic       wr_byte_pulse;
  logic       nack_seen;

  int checks   = 0;
  int failures = 0;
  int wr_pulses = 0;
  int nacks     = 0;
  int viol      = 0;
  int exp_wr    = 0;
  logic scl_prev = 1'b1;
  logic drv_prev = 1'b0;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] a0;
    logic [3:0] a1;
  } wr_vec_t;
  wr_vec_t vecs [3];

  assign sda_line = sda_ctl & ~sda_drive_low;

  always #5 clk = ~clk;

  i2c_target_responder dut (
    .axi_clk       (clk),
    .axi_reset     (rst),
    .scl_in        (scl),
    .sda_in        (sda_line),
    .sda_drive_low (sda_drive_low),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_we       (host_we),
    .host_rdata    (host_rdata),
    .busy          (busy),
    .wr_byte_pulse (wr_byte_pulse),
    .nack_seen     (nack_seen)
  );

  // Pulse counters and the "target never moves SDA while SCL is high" monitor
  always @(posedge clk) begin
    if (wr_byte_pulse) wr_pulses <= wr_pulses + 1;
    if (nack_seen) nacks <= nacks + 1;
    if (!rst && scl && scl_prev && (sda_drive_low !== drv_prev)) viol <= viol + 1;
    scl_prev <= scl;
    drv_prev <= sda_drive_low;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [7:0] v);
    sb_t e;
    e.nm = nm;
    e.v  = v;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [7:0] act);
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty actual=%0h expected=none", act);
    end else begin
      e = sbq.pop_front();
      chk(e.nm, 32'(act), 32'(e.v));
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic inj, input logic [3:0] ia, input logic [7:0] id);
    sda_ctl = b;
    wait_q();
    scl = 1'b1;
    if (inj) begin
      repeat (2) @(negedge clk);
      host_addr  = ia;
      host_wdata = id;
      host_we    = 1'b1;
      @(negedge clk);
      host_we = 1'b0;
      repeat (2 * Q - 3) @(negedge clk);
    end else begin
      repeat (2 * Q) @(negedge clk);
    end
    scl = 1'b0;
    wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_ctl = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    b = sda_line;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic start_cond();
    sda_ctl = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    sda_ctl = 1'b0;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic stop_cond();
    sda_ctl = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    sda_ctl = 1'b1;
    wait_q();
  endtask

  task automatic write_byte_inj(input logic [7:0] d, output logic ack,
                                input logic inj, input logic [3:0] ia, input logic [7:0] id);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i], inj && (i == 0), ia, id);
    end
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    write_byte_inj(d, ack, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic wr_ack(input logic [7:0] d, input string nm);
    logic a;
    sb_push(nm, 8'd1);
    write_byte(d, a);
    sb_pop({7'd0, a});
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic chk_reg(input string nm, input logic [3:0] a, input logic [7:0] exp);
    host_addr = a;
    #1;
    chk(nm, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    logic       a;
    logic [7:0] d;

    vecs[0] = '{ptr: 8'h03, d0: 8'h11, d1: 8'h22, a0: 4'h3, a1: 4'h4};
    vecs[1] = '{ptr: 8'h0F, d0: 8'hAA, d1: 8'hBB, a0: 4'hF, a1: 4'h0};
    vecs[2] = '{ptr: 8'h1A, d0: 8'h5C, d1: 8'hE7, a0: 4'hA, a1: 4'hB};

    rst        = 1'b1;
    scl        = 1'b1;
    sda_ctl    = 1'b1;
    host_we    = 1'b0;
    host_addr  = 4'h0;
    host_wdata = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    chk("rst_sda_drive_low", 32'(sda_drive_low), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_pulse", 32'(wr_byte_pulse), 32'd0);
    chk("rst_nack", 32'(nack_seen), 32'd0);
    chk_reg("rst_reg0", 4'h0, 8'h00);
    chk_reg("rst_reg15", 4'hF, 8'h00);

    // Table-driven write transfers, including pointer wrap and pointer modulo
    for (int v = 0; v < 3; v++) begin
      start_cond();
      wr_ack(8'hA0, "wr_addr_ack");
      chk("wr_busy_set", 32'(busy), 32'd1);
      wr_ack(vecs[v].ptr, "wr_ptr_ack");
      wr_ack(vecs[v].d0, "wr_d0_ack");
      wr_ack(vecs[v].d1, "wr_d1_ack");
      stop_cond();
      wait_q();
      exp_wr += 2;
      chk("wr_busy_clr", 32'(busy), 32'd0);
      chk_reg("wr_reg_d0", vecs[v].a0, vecs[v].d0);
      chk_reg("wr_reg_d1", vecs[v].a1, vecs[v].d1);
      chk("wr_pulse_count", 32'(wr_pulses), 32'(exp_wr));
    end

    // Read via repeated START; host writes after byte start affect only later bytes
    host_write(4'h5, 8'hC3);
    start_cond();
    wr_ack(8'hA0, "rd_waddr_ack");
    wr_ack(8'h05, "rd_ptr_ack");
    start_cond();
    wr_ack(8'hA1, "rd_raddr_ack");
    host_write(4'h5, 8'h00);
    host_write(4'h6, 8'h9E);
    sb_push("rd_byte0", 8'hC3);
    read_byte(1'b1, d);
    sb_pop(d);
    chk("rd_busy_mid", 32'(busy), 32'd1);
    sb_push("rd_byte1", 8'h9E);
    read_byte(1'b0, d);
    sb_pop(d);
    chk("rd_nack_count", 32'(nacks), 32'd1);
    chk("rd_busy_after_nack", 32'(busy), 32'd0);
    stop_cond();
    wait_q();
    chk("rd_busy_after_stop", 32'(busy), 32'd0);
    chk_reg("rd_host_reg5", 4'h5, 8'h00);

    // Address mismatch: no ACK, no busy, following bytes ignored
    start_cond();
    sb_push("mm_addr_noack", 8'd0);
    write_byte(8'hA4, a);
    sb_pop({7'd0, a});
    chk("mm_busy", 32'(busy), 32'd0);
    sb_push("mm_b1_noack", 8'd0);
    write_byte(8'h02, a);
    sb_pop({7'd0, a});
    sb_push("mm_b2_noack", 8'd0);
    write_byte(8'h99, a);
    sb_pop({7'd0, a});
    stop_cond();
    wait_q();
    chk_reg("mm_reg2", 4'h2, 8'h00);
    chk("mm_pulse_count", 32'(wr_pulses), 32'(exp_wr));

    // Same-cycle host and I2C write to the same index: I2C wins
    start_cond();
    wr_ack(8'hA0, "sc_addr_ack");
    wr_ack(8'h02, "sc_ptr_ack");
    sb_push("sc_data_ack", 8'd1);
    write_byte_inj(8'h66, a, 1'b1, 4'h2, 8'h55);
    sb_pop({7'd0, a});
    stop_cond();
    wait_q();
    exp_wr += 1;
    chk_reg("sc_same_idx", 4'h2, 8'h66);

    // Same-cycle writes to different indices both land
    start_cond();
    wr_ack(8'hA0, "sd_addr_ack");
    wr_ack(8'h07, "sd_ptr_ack");
    sb_push("sd_data_ack", 8'd1);
    write_byte_inj(8'h5A, a, 1'b1, 4'h9, 8'h3C);
    sb_pop({7'd0, a});
    stop_cond();
    wait_q();
    exp_wr += 1;
    chk_reg("sd_i2c_idx", 4'h7, 8'h5A);
    chk_reg("sd_host_idx", 4'h9, 8'h3C);
    chk("sd_pulse_count", 32'(wr_pulses), 32'(exp_wr));

    // Reset during the 4th read bit while the target pulls SDA low
    host_write(4'hC, 8'h00);
    start_cond();
    wr_ack(8'hA0, "ar_waddr_ack");
    wr_ack(8'h0C, "ar_ptr_ack");
    start_cond();
    wr_ack(8'hA1, "ar_raddr_ack");
    for (int i = 0; i < 3; i++) begin
      recv_bit(a);
    end
    sda_ctl = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    chk("ar_drive_before", 32'(sda_drive_low), 32'd1);
    chk("ar_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_drive_async", 32'(sda_drive_low), 32'd0);
    chk("ar_busy_async", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    wait_q();
    chk_reg("ar_reg3_cleared", 4'h3, 8'h00);
    start_cond();
    wr_ack(8'hA0, "ar_post_addr_ack");
    wr_ack(8'h01, "ar_post_ptr_ack");
    wr_ack(8'h42, "ar_post_data_ack");
    stop_cond();
    wait_q();
    exp_wr += 1;
    chk_reg("ar_post_reg1", 4'h1, 8'h42);
    chk("ar_pulse_count", 32'(wr_pulses), 32'(exp_wr));

    chk("sda_stable_while_scl_high", 32'(viol), 32'd0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
